// File: rtl/diff_tx_seq_pkg.sv
// Shared constants for the link-test word sequencer: state codes, PRBS7 seed/taps
// and default lane patterns.
package diff_tx_seq_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'b00;
  localparam tx_state_t ST_TRAIN = 2'b01;
  localparam tx_state_t ST_PRBS  = 2'b10;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  localparam logic [15:0] DEF_TRAIN_WORD = 16'hF0F0;
  localparam logic [15:0] DEF_IDLE_WORD  = 16'h0000;

  // x^7+x^6+1 Fibonacci step; the bit shifted out is s[6]
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/diff_tx_seq_prbs.sv
// Parallel PRBS7 generator: WORDWIDTH serial steps per advance, oldest bit in the MSB.
// reseed makes the current word come from the seed, so the first word after reseed is usable at once.
module prbs7_word_gen
  import diff_tx_seq_pkg::*;
#(
  parameter int WORDWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  input  logic                 reseed,
  output logic [WORDWIDTH-1:0] word
);

  logic [6:0] lfsr;
  logic [6:0] base;
  logic [6:0] nxt;

  always_comb begin
    word = '0;
    nxt  = reseed ? PRBS7_SEED : lfsr;
    base = nxt;
    for (int i = 0; i < WORDWIDTH; i++) begin
      word[WORDWIDTH-1-i] = nxt[6];
      nxt = prbs7_step(nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr <= PRBS7_SEED;
    else if (advance) lfsr <= nxt;
    else if (reseed)  lfsr <= base;
  end

endmodule

// File: rtl/diff_tx_seq.sv
// Link-test sequencer: IDLE -> TRAIN (fixed alignment words) -> PRBS7 stream -> IDLE,
// with stop, length limit, single-bit error injection and a saturating word count.
module diff_tx_seq
  import diff_tx_seq_pkg::*;
#(
  parameter int                   WORDWIDTH   = 16,
  parameter int                   TRAIN_WORDS = 64,
  parameter logic [WORDWIDTH-1:0] TRAIN_WORD  = WORDWIDTH'(DEF_TRAIN_WORD),
  parameter logic [WORDWIDTH-1:0] IDLE_WORD   = WORDWIDTH'(DEF_IDLE_WORD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          prbs_len,
  input  logic                 inject_err,
  output logic [WORDWIDTH-1:0] word_out,
  output logic                 word_valid,
  output logic                 busy,
  output logic [1:0]           state_o,
  output logic [31:0]          words_sent
);

  localparam int CW = $clog2(TRAIN_WORDS + 1);

  tx_state_t            state;
  logic [CW-1:0]        train_cnt;
  logic [31:0]          len_q;
  logic                 err_pend;
  logic [WORDWIDTH-1:0] gen_word;
  logic                 last_train;
  logic                 prbs_done;
  logic                 emit;

  assign last_train = (state == ST_TRAIN) && (train_cnt == CW'(TRAIN_WORDS));
  assign prbs_done  = (len_q != 32'd0) && (words_sent == len_q);
  // emit: this edge puts a PRBS word on the lane (first one comes straight from the seed)
  assign emit       = !stop && (last_train || ((state == ST_PRBS) && !prbs_done));
  assign state_o    = state;

  prbs7_word_gen #(.WORDWIDTH(WORDWIDTH)) u_prbs (
    .clk     (clk),
    .rst     (rst),
    .advance (emit),
    .reseed  (state == ST_TRAIN),
    .word    (gen_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_out   <= IDLE_WORD;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      words_sent <= '0;
      train_cnt  <= '0;
      len_q      <= '0;
      err_pend   <= 1'b0;
    end else if (emit) begin
      state      <= ST_PRBS;
      word_out   <= gen_word ^ {{(WORDWIDTH-1){1'b0}}, err_pend};
      word_valid <= 1'b1;
      busy       <= 1'b1;
      // a pending error is consumed here; a fresh inject on this edge re-arms it
      err_pend   <= inject_err;
      if (last_train)                      words_sent <= 32'd1;
      else if (words_sent != 32'hFFFF_FFFF) words_sent <= words_sent + 32'd1;
    end else if (state == ST_IDLE) begin
      err_pend <= err_pend | inject_err;
      if (start && !stop) begin
        state      <= ST_TRAIN;
        word_out   <= TRAIN_WORD;
        word_valid <= 1'b1;
        busy       <= 1'b1;
        train_cnt  <= CW'(1);
        words_sent <= '0;
        len_q      <= prbs_len;
      end
    end else if (state == ST_TRAIN && !stop) begin
      train_cnt <= CW'(train_cnt + 1'b1);
      err_pend  <= err_pend | inject_err;
    end else begin
      state      <= ST_IDLE;
      word_out   <= IDLE_WORD;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      err_pend   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_diff_tx_seq.sv
// Randomized bench for diff_tx_seq: bursts are checked word by word against a
// PRBS7 bit-sequence model and the burst framing/error-injection rules.
module tb_diff_tx_seq;

  localparam int TW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] prbs_len = '0;
  logic        inject_err = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        busy;
  logic [1:0]  state_o;
  logic [31:0] words_sent;

  int checks = 0;
  int errors = 0;

  bit          pbits [127];
  bit          pend;
  logic [31:0] last_ws;
  logic [15:0] first_prbs;
  int          last_vcnt;

  always #5 clk = ~clk;

  diff_tx_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .prbs_len   (prbs_len),
    .inject_err (inject_err),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .state_o    (state_o),
    .words_sent (words_sent)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // PRBS7 output bits obey o[n+7] = o[n] ^ o[n+1]; the stream repeats every 127 bits
  function automatic logic [15:0] ref_word(input int k);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[15-b] = pbits[(16*k + b) % 127];
    return w;
  endfunction

  task automatic chk_idle(input string tag, input logic [31:0] ws);
    chk({tag, "_word"},  32'(word_out), 32'h0);
    chk({tag, "_valid"}, 32'(word_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_state"}, 32'(state_o), 32'h0);
    chk({tag, "_ws"},    words_sent, ws);
  endtask

  // Plays one burst from IDLE. Indices n count words since start (0..TW-1 train, then PRBS).
  // stop_n / inj_n / rst_n: word index during which that input is asserted (-1 = never).
  task automatic burst(input int len, input int stop_n, input int inj_n,
                       input bit inj_rand, input int rst_n);
    int          n;
    int          vcnt;
    int          ws_end;
    bit          done;
    bit          cur_err;
    logic        inj;
    logic        stp;
    logic [15:0] ew;
    n = 0; vcnt = 0; ws_end = 0; done = 0; cur_err = 0;
    start = 1'b1; stop = 1'b0; prbs_len = 32'(len);
    inj = inj_rand && ($urandom % 4 == 0);
    inject_err = inj;
    @(posedge clk);
    pend = pend | inj;
    #1 start = 1'b0; inject_err = 1'b0; prbs_len = $urandom;
    for (int guard = 0; guard < 3000; guard++) begin
      @(negedge clk);
      if (done) begin
        chk_idle("end", 32'(ws_end));
        last_ws = 32'(ws_end);
        last_vcnt = vcnt;
        return;
      end
      vcnt += int'(word_valid);
      ew = (n < TW) ? 16'hF0F0 : ref_word(n - TW) ^ {15'b0, cur_err};
      if (n == TW) first_prbs = word_out;
      chk("word",  32'(word_out), 32'(ew));
      chk("valid", 32'(word_valid), 32'h1);
      chk("busy",  32'(busy), 32'h1);
      chk("state", 32'(state_o), (n < TW) ? 32'h1 : 32'h2);
      chk("ws",    words_sent, (n < TW) ? 32'h0 : 32'(n - TW + 1));
      if (n == rst_n) begin
        #1 rst = 1'b1;
        #1 chk_idle("rst", 32'h0);
        #1 rst = 1'b0;
        pend = 0; last_ws = '0;
        return;
      end
      stp = (n == stop_n);
      inj = (n == inj_n) || (inj_rand && ($urandom % 5 == 0));
      stop = stp; inject_err = inj;
      start = ($urandom % 6 == 0);
      prbs_len = $urandom;
      @(posedge clk);
      if (stp || (len != 0 && n + 1 == TW + len)) begin
        done = 1;
        pend = 0;
        ws_end = (n >= TW) ? n - TW + 1 : 0;
      end else begin
        n++;
        if (n >= TW) begin
          cur_err = pend;
          pend = inj;
        end else begin
          pend = pend | inj;
        end
      end
      #1 start = 1'b0; stop = 1'b0; inject_err = 1'b0;
    end
    chk("burst_timeout", 32'h1, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 7; i++) pbits[i] = 1'b1;
    for (int i = 7; i < 127; i++) pbits[i] = pbits[i-7] ^ pbits[i-6];
    pend = 0; last_ws = '0; first_prbs = '0; last_vcnt = 0;

    // reset state, then quiet idle
    #2 chk_idle("reset", 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("idle", 32'h0);
    end

    // fixed-length burst
    burst(4, -1, -1, 0, -1);
    chk("len4_first", 32'(first_prbs), 32'hFE04);
    chk("len4_vcnt",  32'(last_vcnt), 32'd68);

    // continuous mode past 1000 words, then stop at PRBS word 500
    burst(0, TW + 1049, -1, 0, -1);
    chk("cont_ws", last_ws, 32'd1050);
    burst(0, TW + 499, -1, 0, -1);
    chk("stop500_ws", last_ws, 32'd500);

    // error injected during TRAIN lands on the first PRBS word only
    burst(6, -1, 10, 0, -1);
    chk("inj_first", 32'(first_prbs), 32'hFE05);

    // start with stop in IDLE stays idle; stop alone in IDLE does nothing
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk); chk_idle("startstop", last_ws);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk); chk_idle("stopidle", last_ws);

    // stop during TRAIN
    burst(10, 20, -1, 0, -1);

    // async reset mid-PRBS, then a clean burst
    burst(0, -1, -1, 1, TW + 37);
    burst(3, -1, -1, 0, -1);
    chk("post_rst_first", 32'(first_prbs), 32'hFE04);

    // randomized bursts with random injections, stops and ignored start/len changes
    for (int r = 0; r < 8; r++) begin
      int len;
      int sn;
      len = int'($urandom_range(1, 40));
      sn  = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, TW + len + 4));
      burst(len, sn, -1, 1, -1);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
